alu_result_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_result_stage_if.sv | 25 ++
 rtl/alu_core.sv | 58 +++++
 rtl/alu_result_stage.sv | 113 +++++++++++
 tb/tb_alu_result_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the ALU result stage (ALU_SATURATE_EN selects clamping in alu_core)
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  localparam int STAT_Z = 2;
  localparam int STAT_N = 1;
  localparam int STAT_V = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [2:0] pack_status(input logic z, input logic n, input logic v);
    logic [2:0] s;
    s         = '0;
    s[STAT_Z] = z;
    s[STAT_N] = n;
    s[STAT_V] = v;
    return s;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - upstream operand and downstream result handshake bundle
interface alu_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [1:0]       alu_op;
  logic             load_status;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c_out;
  logic [2:0]       status;

  modport slave (
    input  in_valid, ain, bin, alu_op, load_status, out_ready,
    output in_ready, out_valid, c_out, status
  );

  modport master (
    output in_valid, ain, bin, alu_op, load_status, out_ready,
    input  in_ready, out_valid, c_out, status
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU with Z/N/V flags; ALU_SATURATE_EN clamps ADD/SUB overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [1:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  assign sum  = ain + bin;
  assign diff = ain - bin;

  always_comb begin
    raw = '0;
    ovf = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        raw = sum;
        ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_SUB: begin
        raw = diff;
        ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (diff[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_AND: raw = ain & bin;
      ALU_NOT: raw = ~bin;
      default: raw = '0;
    endcase
  end

`ifdef ALU_SATURATE_EN
  // Overflow direction always follows the sign of A for both ADD and SUB.
  always_comb begin
    result = raw;
    if (ovf) begin
      result = ain[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign result = raw;
`endif

  assign z = (result == '0);
  assign n = result[WIDTH-1];
  assign v = ovf;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result with status register and 2-entry skid buffer (ALU_SATURATE_EN passes to alu_core)
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  alu_result_stage_if.slave bus
);

  skid_state_e      state;
  skid_state_e      state_next;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] skid_reg;
  logic [2:0]       status_reg;

  logic [WIDTH-1:0] core_result;
  logic             core_z;
  logic             core_n;
  logic             core_v;

  logic             accept;
  logic             drain;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .ain    (bus.ain),
    .bin    (bus.bin),
    .alu_op (bus.alu_op),
    .result (core_result),
    .z      (core_z),
    .n      (core_n),
    .v      (core_v)
  );

  // Both handshake outputs derive only from the state register, never from inputs.
  assign bus.in_ready  = (state != ST_TWO);
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.c_out     = out_reg;
  assign bus.status    = status_reg;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next   = ST_ONE;
          load_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_next    = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      if (load_out_new) begin
        out_reg <= core_result;
      end else if (load_out_skid) begin
        out_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= core_result;
      end
    end
  end

  // Status tracks accepts, not drains, so it may run ahead of c_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_reg <= '0;
    end else if (accept && bus.load_status) begin
      status_reg <= pack_status(core_z, core_n, core_v);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage (honours ALU_SATURATE_EN)
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_result_stage_if #(.WIDTH(W)) bus ();

  alu_result_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] exp_q[$];
  logic [2:0]  exp_status = 3'b000;

  // Returns {result, Z, N, V} from signed integer arithmetic.
  function automatic logic [18:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    int          sa;
    int          sb;
    int          s;
    logic [15:0] r;
    logic        v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = 0;
    v  = 1'b0;
    r  = '0;
    case (op)
      2'b00, 2'b01: begin
        s = (op == 2'b00) ? sa + sb : sa - sb;
        v = (s > 32767) || (s < -32768);
        r = s[15:0];
`ifdef ALU_SATURATE_EN
        if (v) r = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
      2'b10: r = a & b;
      default: r = ~b;
    endcase
    return {r, (r == 16'h0000), r[15], v};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_model();
    check("in_ready", {15'd0, bus.in_ready}, {15'd0, exp_q.size() < 2});
    check("out_valid", {15'd0, bus.out_valid}, {15'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) check("c_out", bus.c_out, exp_q[0]);
    check("status", {13'd0, bus.status}, {13'd0, exp_status});
  endtask

  // Called at a falling edge; drives, checks, advances the model across one rising edge.
  task automatic cycle(input bit iv, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input bit ls, input bit ordy);
    bit          acc;
    bit          drn;
    logic [18:0] res;
    bus.in_valid    = iv;
    bus.ain         = a;
    bus.bin         = b;
    bus.alu_op      = op;
    bus.load_status = ls;
    bus.out_ready   = ordy;
    check_model();
    acc = iv && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && ordy;
    res = ref_alu(a, b, op);
    @(posedge clk);
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(res[18:3]);
    if (acc && ls) exp_status = res[2:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 16'h0, 16'h0, 2'b00, 0, 1);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.ain         = '0;
    bus.bin         = '0;
    bus.alu_op      = 2'b00;
    bus.load_status = 1'b0;
    bus.out_ready   = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    check("rst_status", {13'd0, bus.status}, 16'd0);
    reset = 1'b0;
    idle(3);

    cycle(1, 16'h7FFF, 16'h0001, 2'b00, 1, 1);
`ifdef ALU_SATURATE_EN
    check("add_ovf_c", bus.c_out, 16'h7FFF);
    check("add_ovf_st", {13'd0, bus.status}, 16'h0001);
`else
    check("add_ovf_c", bus.c_out, 16'h8000);
    check("add_ovf_st", {13'd0, bus.status}, 16'h0003);
`endif

    cycle(1, 16'h0005, 16'h0005, 2'b01, 1, 1);
    check("sub_c", bus.c_out, 16'h0000);
    check("sub_st", {13'd0, bus.status}, 16'h0004);
    cycle(1, 16'h1234, 16'h00FF, 2'b11, 0, 1);
    check("not_c", bus.c_out, 16'hFF00);
    check("not_st", {13'd0, bus.status}, 16'h0004);
    idle(2);

    cycle(1, 16'hF0F0, 16'hFF00, 2'b10, 0, 0);
    cycle(1, 16'h1234, 16'hFFFF, 2'b10, 0, 0);
    check("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
    check("bp_hold_c", bus.c_out, 16'hF000);
    cycle(1, 16'hAAAA, 16'h0FF0, 2'b10, 0, 0);
    check("bp_still_c", bus.c_out, 16'hF000);
    cycle(1, 16'hAAAA, 16'h0FF0, 2'b10, 0, 1);
    check("bp_second_c", bus.c_out, 16'h1234);
    cycle(1, 16'hAAAA, 16'h0FF0, 2'b10, 0, 1);
    check("bp_third_c", bus.c_out, 16'h0AA0);
    idle(2);

    for (int i = 0; i < 8; i++) begin
      cycle(1, 16'(i), 16'h0001, 2'b00, 0, 1);
      check("stream_c", bus.c_out, 16'(i + 1));
      check("stream_rdy", {15'd0, bus.in_ready}, 16'd1);
    end
    idle(2);

    cycle(1, 16'h1111, 16'h2222, 2'b00, 1, 0);
    cycle(1, 16'h3333, 16'h4444, 2'b00, 1, 0);
    check("fill_two", {15'd0, bus.in_ready}, 16'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    check("mid_rst_ready", {15'd0, bus.in_ready}, 16'd1);
    check("mid_rst_status", {13'd0, bus.status}, 16'd0);
    exp_q.delete();
    exp_status = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) != 0));
    end
    idle(4);
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
